// File: rtl/layer_pkg.sv
// Shared types and defaults for the three-class layer vote block.
package layer_pkg;

  localparam int unsigned WINDOW_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 8;

  // Sample counter is wide enough for the largest legal window (255).
  localparam int unsigned SCNT_W = 8;

  // class_id value reported when no class received any vote.
  localparam logic [1:0] CLASS_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DECIDE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage : layer_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule : sat_counter

// File: rtl/layer_vote.sv
// Windowed majority vote over three class activations with a
// valid/ready decision output held until consumed.
module layer_vote
  import layer_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       class_id,
  output logic [CNT_W-1:0] class_cnt,
  output logic             tie
);

  localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(WINDOW - 1);

  state_e            state_q;
  logic [SCNT_W-1:0] sample_cnt_q;
  logic              out_valid_q;
  logic [1:0]        class_id_q;
  logic [CNT_W-1:0]  class_cnt_q;
  logic              tie_q;

  logic              accept_c;
  logic              last_c;
  logic              vote_clr_c;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  cnt2;

  logic [1:0]        best_id_c;
  logic [CNT_W-1:0]  best_cnt_c;
  logic              best_tie_c;
  logic [1:0]        n_at_max_c;

  // Handshake decode: samples only enter while accumulating.
  assign in_ready   = (state_q == ST_ACCUM);
  assign accept_c   = in_valid && in_ready;
  assign last_c     = accept_c && (sample_cnt_q == LAST_IDX);
  assign vote_clr_c = (state_q == ST_HOLD) && out_ready;

  // One saturating vote counter per class; simultaneous activations all count.
  sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_c && s0),
    .clr   (vote_clr_c),
    .count (cnt0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_c && s1),
    .clr   (vote_clr_c),
    .count (cnt1)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt2 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_c && s2),
    .clr   (vote_clr_c),
    .count (cnt2)
  );

  // Argmax with lowest-index tie break; an empty window reports NONE.
  always_comb begin
    best_id_c  = 2'd0;
    best_cnt_c = cnt0;
    if (cnt1 > best_cnt_c) begin
      best_id_c  = 2'd1;
      best_cnt_c = cnt1;
    end
    if (cnt2 > best_cnt_c) begin
      best_id_c  = 2'd2;
      best_cnt_c = cnt2;
    end
    n_at_max_c = 2'(cnt0 == best_cnt_c) + 2'(cnt1 == best_cnt_c)
               + 2'(cnt2 == best_cnt_c);
    best_tie_c = (n_at_max_c > 2'd1);
    if (best_cnt_c == '0) begin
      best_id_c  = CLASS_NONE;
      best_tie_c = 1'b0;
    end
  end

  // Control FSM: accumulate a window, latch the decision, hold until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      sample_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      class_id_q   <= 2'd0;
      class_cnt_q  <= '0;
      tie_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_c) begin
            if (last_c) begin
              sample_cnt_q <= '0;
              state_q      <= ST_DECIDE;
            end else begin
              sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
            end
          end
        end
        ST_DECIDE: begin
          class_id_q  <= best_id_c;
          class_cnt_q <= best_cnt_c;
          tie_q       <= best_tie_c;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign class_id  = class_id_q;
  assign class_cnt = class_cnt_q;
  assign tie       = tie_q;

endmodule : layer_vote

// File: tb/tb_layer_vote.sv
// Scoreboard bench for layer_vote: two instances (WINDOW=4/CNT_W=8 and
// WINDOW=6/CNT_W=2) driven with directed sample windows.
module tb_layer_vote;

  typedef struct {
    logic [1:0] id;
    logic [7:0] cnt;
    logic       tie;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid_a, in_ready_a, s0_a, s1_a, s2_a;
  logic       out_valid_a, out_ready_a, tie_a;
  logic [1:0] class_id_a;
  logic [7:0] class_cnt_a;

  logic       in_valid_b, in_ready_b, s0_b, s1_b, s2_b;
  logic       out_valid_b, out_ready_b, tie_b;
  logic [1:0] class_id_b;
  logic [1:0] class_cnt_b;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  layer_vote #(.WINDOW(4), .CNT_W(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .s0        (s0_a),
    .s1        (s1_a),
    .s2        (s2_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .class_id  (class_id_a),
    .class_cnt (class_cnt_a),
    .tie       (tie_a)
  );

  layer_vote #(.WINDOW(6), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .s0        (s0_b),
    .s1        (s1_b),
    .s2        (s2_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .class_id  (class_id_b),
    .class_cnt (class_cnt_b),
    .tie       (tie_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: timeout (t=%0t)", name, $time);
  endtask

  // Monitors: compare every consumed decision against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
      if (q_a.size() == 0) begin
        fail_now("a_unexpected_decision");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_class_id", int'(class_id_a), int'(e.id));
        chk("a_class_cnt", int'(class_cnt_a), int'(e.cnt));
        chk("a_tie", int'(tie_a), int'(e.tie));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
      if (q_b.size() == 0) begin
        fail_now("b_unexpected_decision");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_class_id", int'(class_id_b), int'(e.id));
        chk("b_class_cnt", int'(class_cnt_b), int'(e.cnt));
        chk("b_tie", int'(tie_b), int'(e.tie));
      end
    end
  end

  // Present one sample {s2,s1,s0} and hold it until it is accepted.
  task automatic send(input bit which, input logic [2:0] v);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    if (!which) begin
      in_valid_a = 1'b1; {s2_a, s1_a, s0_a} = v;
    end else begin
      in_valid_b = 1'b1; {s2_b, s1_b, s0_b} = v;
    end
    while (!done) begin
      @(negedge clk);
      if ((which ? in_ready_b : in_ready_a) === 1'b1) done = 1'b1;
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 50) begin
        fail_now("send_accept");
        done = 1'b1;
      end
    end
    if (!which) in_valid_a = 1'b0;
    else        in_valid_b = 1'b0;
  endtask

  // Idle cycles in ACCUM with activations asserted but in_valid low.
  task automatic idle_a(input int n);
    in_valid_a = 1'b0;
    {s2_a, s1_a, s0_a} = 3'b111;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Wait until the scoreboard has consumed all expected decisions.
  task automatic wait_drain(input bit which);
    int guard;
    guard = 0;
    while ((which ? q_b.size() : q_a.size()) != 0 && guard < 60) begin
      @(negedge clk); #1;
      guard++;
    end
    if ((which ? q_b.size() : q_a.size()) != 0) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic push_a(input logic [1:0] id, input logic [7:0] cnt, input logic t);
    exp_t e;
    e.id = id; e.cnt = cnt; e.tie = t;
    q_a.push_back(e);
  endtask

  initial begin
    logic [2:0] win [4];
    rst_n = 1'b0;
    in_valid_a = 1'b0; {s2_a, s1_a, s0_a} = 3'b000; out_ready_a = 1'b1;
    in_valid_b = 1'b0; {s2_b, s1_b, s0_b} = 3'b000; out_ready_b = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_class_id", int'(class_id_a), 0);
    chk("rst_class_cnt", int'(class_cnt_a), 0);
    chk("rst_tie", int'(tie_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;

    // Clear class-0 majority, with latency check.
    push_a(2'd0, 8'd3, 1'b0);
    win = '{3'b001, 3'b001, 3'b010, 3'b001};
    foreach (win[i]) send(1'b0, win[i]);
    @(negedge clk);
    chk("lat_decide_no_valid", int'(out_valid_a), 0);
    chk("lat_decide_in_ready", int'(in_ready_a), 0);
    @(negedge clk);
    chk("lat_valid_at_n2", int'(out_valid_a), 1);
    wait_drain(1'b0);

    // Three-way tie with idle gaps between samples.
    push_a(2'd0, 8'd2, 1'b1);
    win = '{3'b011, 3'b011, 3'b100, 3'b100};
    foreach (win[i]) begin
      send(1'b0, win[i]);
      idle_a(2);
    end
    wait_drain(1'b0);

    // Empty window reports NONE.
    push_a(2'd3, 8'd0, 1'b0);
    repeat (4) send(1'b0, 3'b000);
    wait_drain(1'b0);

    // Backpressure: decision held while in_valid toggles.
    out_ready_a = 1'b0;
    push_a(2'd1, 8'd2, 1'b0);
    win = '{3'b010, 3'b010, 3'b001, 3'b100};
    foreach (win[i]) send(1'b0, win[i]);
    for (int i = 0; i < 10 && out_valid_a !== 1'b1; i++) @(negedge clk);
    chk("hold_valid_seen", int'(out_valid_a), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid_a = i[0];
      {s2_a, s1_a, s0_a} = 3'b111;
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid_a), 1);
      chk("hold_in_ready", int'(in_ready_a), 0);
      chk("hold_class_id", int'(class_id_a), 1);
      chk("hold_class_cnt", int'(class_cnt_a), 2);
      chk("hold_tie", int'(tie_a), 0);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    wait_drain(1'b0);
    @(negedge clk);
    chk("post_hold_in_ready", int'(in_ready_a), 1);
    chk("post_hold_out_valid", int'(out_valid_a), 0);
    @(posedge clk); #1;
    // Counters must be zero: an all-zero window decides NONE.
    push_a(2'd3, 8'd0, 1'b0);
    repeat (4) send(1'b0, 3'b000);
    wait_drain(1'b0);

    // Mid-window reset discards earlier samples.
    send(1'b0, 3'b001);
    send(1'b0, 3'b001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready_a), 1);
    chk("midrst_out_valid", int'(out_valid_a), 0);
    @(posedge clk); #1;
    push_a(2'd1, 8'd3, 1'b0);
    win = '{3'b010, 3'b010, 3'b100, 3'b010};
    foreach (win[i]) send(1'b0, win[i]);
    wait_drain(1'b0);

    // Saturation on the narrow instance: all counters stick at 3.
    begin
      exp_t e;
      e.id = 2'd0; e.cnt = 8'd3; e.tie = 1'b1;
      q_b.push_back(e);
    end
    repeat (6) send(1'b1, 3'b111);
    wait_drain(1'b1);

    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_layer_vote

// File: doc/layer_vote.md
LAYER_VOTE -- requirements
Module: layer_vote

Interface
REQ-001 Parameter WINDOW, default 16; samples per decision window, 2..255.
REQ-002 Parameter CNT_W, default 8; per-class vote counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset: synchronous, active-low.
REQ-005 in_valid  input  1  s0/s1/s2 carry a valid layer output this cycle.
REQ-006 in_ready  output  1  block accepts a sample this cycle (high only in ACCUM).
REQ-007 s0, s1, s2  input  1 each  class-0/1/2 activations from the upstream layer stage.
REQ-008 out_valid  output  1  a decision is presented.
REQ-009 out_ready  input  1  downstream consumes the decision.
REQ-010 class_id  output  2  winning class 0..2; 3 = NONE.
REQ-011 class_cnt  output  CNT_W  vote count of the winning class.
REQ-012 tie  output  1  another class has the same maximum count.

Function
REQ-013 FSM states ACCUM, DECIDE and HOLD; reset state is ACCUM.
REQ-014 Sample accepted when in_valid && in_ready; each asserted s0..s2 increments its own counter in the same cycle, so simultaneous activations all count.
REQ-015 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-016 Sample counter counts accepted samples; on acceptance of sample WINDOW, next state is DECIDE and the sample counter clears.
REQ-017 DECIDE lasts exactly one cycle: registers the argmax of the three counters; ties resolve to the lowest index with tie=1; all counts zero gives class_id=3, class_cnt=0, tie=0.
REQ-018 Latency: last sample accepted in cycle N, DECIDE in N+1, out_valid=1 from N+2.
REQ-019 HOLD: out_valid=1; class_id, class_cnt and tie stay stable until out_ready=1.
REQ-020 out_valid && out_ready: vote counters clear and the next state is ACCUM, with in_ready=1 in the following cycle.
REQ-021 in_valid is ignored and s0..s2 are not counted in DECIDE or HOLD.
REQ-022 in_valid=0 cycles in ACCUM neither advance the sample counter nor change the votes.
REQ-023 out_ready asserted outside HOLD has no effect.

Reset
REQ-024 rst_n=0 at a clock edge, in any state and including mid-window: state=ACCUM, all counters=0, out_valid=0, class_id=0, class_cnt=0, tie=0.
REQ-025 in_ready=1 in the first cycle after rst_n returns high; samples accepted before reset are discarded.

Structure
REQ-026 Shared package layer_pkg holds the state enum, CLASS_NONE=2'd3, and the WINDOW/CNT_W defaults.
REQ-027 The saturating counter is one sub-module, sat_counter (inc, clr, CNT_W), instantiated three times; the FSM and argmax stay in layer_vote.

Verification
REQ-028 WINDOW=4; samples {s2,s1,s0} = 001,001,010,001 with in_valid=1 and out_ready=1 -> out_valid two cycles after the 4th sample; class_id=0, class_cnt=3, tie=0.
REQ-029 WINDOW=4; samples 011,011,100,100 -> class_id=0, class_cnt=2, tie=1.
REQ-030 WINDOW=4; all samples 000 -> class_id=3, class_cnt=0, tie=0.
REQ-031 CNT_W=2, WINDOW=6; all samples 111 -> every counter saturates at 3; result is class_id=0, class_cnt=3, tie=1.
REQ-032 out_ready held low 5 cycles in HOLD while in_valid toggles -> outputs stable, in_ready=0, no votes counted; out_ready=1 -> in_ready=1 in the next cycle with counters at 0.
REQ-033 rst_n=0 for one cycle after 2 of 4 samples -> next window decides only on post-reset samples.
